// File: rtl/jamma_pkg.sv
// Shared constants and helpers for the JAMMA input conditioning path.
// Build option: JAMMA_EVT_TIMESTAMP_EN widens events with a 16-bit tick timestamp.
package jamma_pkg;

    localparam int JAMMA_NUM_IN = 29;
    localparam int JAMMA_IDX_W  = 5;
    localparam int JAMMA_TS_W   = 16;

`ifdef JAMMA_EVT_TIMESTAMP_EN
    localparam bit JAMMA_TS_EN = 1'b1;
`else
    localparam bit JAMMA_TS_EN = 1'b0;
`endif

    // Event word layout: {[ts], level, index}
    localparam int JAMMA_EVT_IDX_LSB = 0;
    localparam int JAMMA_EVT_LVL_BIT = JAMMA_IDX_W;
    localparam int JAMMA_EVT_TS_LSB  = JAMMA_IDX_W + 1;
    localparam int JAMMA_EVT_W       = JAMMA_EVT_TS_LSB + (JAMMA_TS_EN ? JAMMA_TS_W : 0);

    function automatic logic [JAMMA_IDX_W-1:0] jamma_lowest_set(
        input logic [JAMMA_NUM_IN-1:0] vec
    );
        logic [JAMMA_IDX_W-1:0] idx;
        idx = '0;
        for (int i = JAMMA_NUM_IN - 1; i >= 0; i--) begin
            if (vec[i]) idx = JAMMA_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jamma_evt_fifo.sv
// Show-ahead synchronous FIFO for input change events; full/empty are registered.
module jamma_evt_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // Requests against the wrong flag are dropped here, so callers may issue them freely.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/jamma_input_debounce.sv
// Synchronise, debounce and hold the 29 JAMMA inputs; queue level changes as events.
// Build option: JAMMA_EVT_TIMESTAMP_EN adds a 16-bit tick timestamp to each event.
module jamma_input_debounce
    import jamma_pkg::*;
#(
    parameter int SAMPLE_DIV = 16,
    parameter int DEB_LEN    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [JAMMA_NUM_IN-1:0] P_raw,
    output logic [JAMMA_NUM_IN-1:0] P_clean,
    output logic                    evt_valid,
    output logic [JAMMA_EVT_W-1:0]  evt_data,
    input  logic                    evt_pop,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int              PRE_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]      DEB_MAX = 4'(DEB_LEN - 1);

    logic [JAMMA_NUM_IN-1:0] sync1_q;
    logic [JAMMA_NUM_IN-1:0] sync2_q;
    logic [JAMMA_NUM_IN-1:0] clean_q;
    logic [JAMMA_NUM_IN-1:0] clean_d;
    logic [JAMMA_NUM_IN-1:0] pending_q;
    logic [JAMMA_NUM_IN-1:0] pending_d;
    logic [JAMMA_NUM_IN-1:0] flip;
    logic [JAMMA_NUM_IN-1:0] clear;
    logic [3:0]              deb_cnt_q [JAMMA_NUM_IN];
    logic [3:0]              deb_cnt_d [JAMMA_NUM_IN];
    logic [PRE_W-1:0]        pre_q;
    logic                    tick_q;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    collision;

    logic                    push;
    logic [JAMMA_IDX_W-1:0]  push_idx;
    logic [JAMMA_EVT_W-1:0]  push_word;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // tick_q is high for exactly one clk, the cycle in which the prescaler reads 0 after a wrap.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (pre_q == PRE_MAX) begin
            pre_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            pre_q  <= pre_q + PRE_W'(1);
            tick_q <= 1'b0;
        end
    end

`ifdef JAMMA_EVT_TIMESTAMP_EN
    logic [JAMMA_TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ts_q <= '0;
        end else if (tick_q) begin
            ts_q <= ts_q + JAMMA_TS_W'(1);
        end
    end
`endif

    always_comb begin
        clean_d = clean_q;
        flip    = '0;
        for (int i = 0; i < JAMMA_NUM_IN; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
        end
        if (tick_q) begin
            for (int i = 0; i < JAMMA_NUM_IN; i++) begin
                if (sync2_q[i] == clean_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == DEB_MAX) begin
                    clean_d[i]   = sync2_q[i];
                    deb_cnt_d[i] = '0;
                    flip[i]      = 1'b1;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Scanner: lowest pending index first. A new flip on the bit being cleared wins,
    // so its level is picked up again by a later push rather than lost.
    always_comb begin
        push     = (|pending_q) & ~fifo_full;
        push_idx = jamma_lowest_set(pending_q);
        clear    = '0;
        if (push) begin
            clear[push_idx] = 1'b1;
        end
        pending_d = (pending_q & ~clear) | flip;
        collision = |(flip & pending_q & ~clear);
        ovf_d     = collision | (ovf_q & ~ovf_clr);
    end

    always_comb begin
        push_word = '0;
        push_word[JAMMA_EVT_IDX_LSB +: JAMMA_IDX_W] = push_idx;
        push_word[JAMMA_EVT_LVL_BIT]                = clean_q[push_idx];
`ifdef JAMMA_EVT_TIMESTAMP_EN
        push_word[JAMMA_EVT_TS_LSB +: JAMMA_TS_W]   = ts_q;
`endif
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            clean_q   <= '1;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < JAMMA_NUM_IN; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= P_raw;
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < JAMMA_NUM_IN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Event port handshake: evt_valid means evt_data holds the head entry; the entry is
    // consumed on any clk where evt_pop=1 and evt_valid=1; evt_pop with evt_valid=0 is a no-op.
    jamma_evt_fifo #(
        .W     (JAMMA_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk         (clk),
        .nReset      (nReset),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (evt_pop),
        .dout_o      (evt_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!nReset)
        fifo_count <= ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));

    assign P_clean   = clean_q;
    assign evt_valid = ~fifo_empty;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_jamma_input_debounce.sv
// Self-checking bench for jamma_input_debounce with an expected-event queue.
module tb_jamma_input_debounce;
    import jamma_pkg::*;

    localparam int SAMPLE_DIV = 4;
    localparam int DEB_LEN    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam logic [28:0] ALL_ONES = 29'h1FFF_FFFF;

    logic                   clk = 1'b0;
    logic                   nReset;
    logic [28:0]            P_raw;
    logic [28:0]            P_clean;
    logic                   evt_valid;
    logic [JAMMA_EVT_W-1:0] evt_data;
    logic                   evt_pop;
    logic                   ovf;
    logic                   ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    jamma_input_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEB_LEN    (DEB_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .P_raw     (P_raw),
        .P_clean   (P_clean),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_pop   (evt_pop),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] ev(input logic lvl, input int idx);
        return {lvl, 5'(idx)};
    endfunction

    // Drive every masked bit to lvl and expect one event per bit, lowest index first.
    task automatic expect_bits(input logic [28:0] mask, input logic lvl);
        for (int i = 0; i < 29; i++) begin
            if (mask[i]) begin
                P_raw[i] = lvl;
                exp_q.push_back(ev(lvl, i));
            end
        end
    endtask

    task automatic drain(input string tag, input int budget, output int stalls);
        int  waited;
        bit  first;
        stalls = 0;
        first  = 1'b1;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (!evt_valid && waited < budget) begin
                evt_pop = 1'b0;
                step(1);
                waited++;
            end
            if (!evt_valid) begin
                check_eq({tag, "_valid"}, 32'(evt_valid), 32'd1);
                exp_q.delete();
            end else begin
                if (!first) stalls += waited;
                first = 1'b0;
                check_eq(tag, 32'(evt_data[JAMMA_EVT_LVL_BIT:0]), 32'(exp_q.pop_front()));
                evt_pop = 1'b1;
                step(1);
            end
        end
        evt_pop = 1'b0;
    endtask

    task automatic wait_clean(input string tag, input int idx, input logic lvl, input int budget);
        int n;
        n = 0;
        while (P_clean[idx] !== lvl && n < budget) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(P_clean[idx]), 32'(lvl));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int stalls;
        nReset  = 1'b0;
        P_raw   = ALL_ONES;
        evt_pop = 1'b0;
        ovf_clr = 1'b0;
        step(3);
        check_eq("rst_clean", 32'(P_clean), 32'(ALL_ONES));
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_data", 32'(evt_data), 32'd0);
        nReset = 1'b1;

        // Idle inputs: nothing may ever be reported.
        seen = 0;
        repeat (1000) begin
            step(1);
            if (evt_valid || P_clean !== ALL_ONES) seen++;
        end
        check_eq("t1_no_evt", 32'(seen), 32'd0);
        check_eq("t1_ovf", 32'(ovf), 32'd0);

        // Single held-low input.
        expect_bits(29'h20, 1'b0);
        wait_clean("t2_clean", 5, 1'b0, 2 + DEB_LEN * SAMPLE_DIV + SAMPLE_DIV);
        check_eq("t2_valid_at_flip", 32'(evt_valid), 32'd0);
        step(1);
        check_eq("t2_valid_flip_p1", 32'(evt_valid), 32'd1);
        drain("t2_evt", 40, stalls);
        check_eq("t2_valid_after_pop", 32'(evt_valid), 32'd0);
        expect_bits(29'h20, 1'b1);
        drain("t2_release", 40, stalls);

        // Two-tick glitch must be filtered.
        seen = 0;
        P_raw[7] = 1'b0;
        for (int i = 0; i < 48; i++) begin
            step(1);
            if (i == 7) P_raw[7] = 1'b1;
            if (P_clean[7] !== 1'b1 || evt_valid) seen++;
        end
        check_eq("t3_glitch", 32'(seen), 32'd0);

        // Simultaneous flips drain in index order on consecutive clocks.
        expect_bits(29'h209, 1'b0);
        drain("t4_evt", 40, stalls);
        check_eq("t4_consec", 32'(stalls), 32'd0);
        expect_bits(29'h209, 1'b1);
        drain("t4_release", 40, stalls);

        // Overfill: bit 5 stays pending, then collides.
        expect_bits(29'h1E, 1'b0);
        P_raw[5] = 1'b0;
        step(30);
        check_eq("t5_full_valid", 32'(evt_valid), 32'd1);
        check_eq("t5_ovf_before", 32'(ovf), 32'd0);
        check_eq("t5_clean5", 32'(P_clean[5]), 32'd0);
        P_raw[5] = 1'b1;
        exp_q.push_back(ev(1'b1, 5));
        step(30);
        check_eq("t5_ovf_set", 32'(ovf), 32'd1);
        drain("t5_evt", 40, stalls);
        check_eq("t5_ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("t5_ovf_clr", 32'(ovf), 32'd0);
        expect_bits(29'h1E, 1'b1);
        drain("t5_release", 40, stalls);

        // Reset mid-operation with two queued events and one bit mid-debounce.
        P_raw[10] = 1'b0;
        P_raw[11] = 1'b0;
        step(25);
        check_eq("t6_pre_valid", 32'(evt_valid), 32'd1);
        P_raw[12] = 1'b0;
        step(5);
        nReset = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(evt_valid), 32'd0);
        check_eq("t6_rst_clean", 32'(P_clean), 32'(ALL_ONES));
        step(2);
        nReset = 1'b1;
        seen = 0;
        repeat (10) begin
            step(1);
            if (evt_valid || P_clean !== ALL_ONES) seen++;
        end
        check_eq("t6_quiet", 32'(seen), 32'd0);
        exp_q.push_back(ev(1'b0, 10));
        exp_q.push_back(ev(1'b0, 11));
        exp_q.push_back(ev(1'b0, 12));
        drain("t6_reported", 40, stalls);
        expect_bits(29'h1C00, 1'b1);
        drain("t6_release", 40, stalls);

`ifdef JAMMA_EVT_TIMESTAMP_EN
        begin
            logic [15:0] ts0;
            logic [15:0] ts1;
            int          n;
            ts0 = '0;
            ts1 = '0;
            expect_bits(29'h10_0000, 1'b0);
            step(5 * SAMPLE_DIV);
            expect_bits(29'h20_0000, 1'b0);
            step(40);
            n = 0;
            while (!evt_valid && n < 40) begin step(1); n++; end
            check_eq("ts_evt0", 32'(evt_data[JAMMA_EVT_LVL_BIT:0]), 32'(exp_q.pop_front()));
            ts0 = evt_data[JAMMA_EVT_TS_LSB +: JAMMA_TS_W];
            evt_pop = 1'b1;
            step(1);
            evt_pop = 1'b0;
            check_eq("ts_evt1", 32'(evt_data[JAMMA_EVT_LVL_BIT:0]), 32'(exp_q.pop_front()));
            ts1 = evt_data[JAMMA_EVT_TS_LSB +: JAMMA_TS_W];
            check_eq("ts_diff", 32'(16'(ts1 - ts0)), 32'd5);
            evt_pop = 1'b1;
            step(1);
            evt_pop = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
